// File: rtl/gate_window_ctrl_pkg.sv
// Shared types and helpers for the gate-window measurement sequencer.
// Holds the FSM state encoding and the saturation-ceiling helper.
package gate_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } gw_state_e;

    // All-ones value of an n-bit counter (n up to 63).
    function automatic logic [63:0] cnt_max(input int n);
        cnt_max = (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/gate_window_ctrl_evt_edge_det.sv
// Rising-edge detector for the measured event, producing a 1-cycle pulse.
// Build macro EVT_SYNC_EN inserts a SYNC_STAGES-deep synchronizer ahead of it.
module evt_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_event,
    output logic o_edge
);

    logic evt_s;
    logic evt_prev_p0;

    if (SYNC_STAGES < 2) begin : g_bad_sync_depth
        $error("evt_edge_det: SYNC_STAGES must be at least 2");
    end

`ifdef EVT_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], i_event};
        end
    end

    assign evt_s = sync_p[SYNC_STAGES-1];
`else
    assign evt_s = i_event;
`endif

    // History tracks every cycle so a level already high at window open is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_prev_p0 <= 1'b0;
        end else begin
            evt_prev_p0 <= evt_s;
        end
    end

    assign o_edge = evt_s & ~evt_prev_p0;

endmodule

// File: rtl/gate_window_ctrl.sv
// Windowed event counter: arms a gate of programmable length, counts event edges
// inside it and offers the frozen count on a valid/ready port. Optional macro: EVT_SYNC_EN.
module gate_window_ctrl
    import gate_window_ctrl_pkg::*;
#(
    parameter int N_BIT       = 12,
    parameter int W_BIT       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [W_BIT-1:0] i_win_len,
    input  logic             i_abort,
    input  logic             i_event,
    output logic             o_busy,
    output logic             o_gate,
    output logic [N_BIT-1:0] o_result,
    output logic             o_overflow,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam logic [N_BIT-1:0] CNT_MAX   = N_BIT'(cnt_max(N_BIT));
    localparam logic [W_BIT-1:0] TIMER_ONE = W_BIT'(1);

    gw_state_e        state, state_nxt;
    logic [W_BIT-1:0] timer, timer_nxt;
    logic [N_BIT-1:0] cnt, cnt_nxt, cnt_upd;
    logic             ovf, ovf_nxt, ovf_upd;
    logic [N_BIT-1:0] result_q, result_nxt;
    logic             res_ovf_q, res_ovf_nxt;
    logic             evt_edge;

    function automatic logic [N_BIT-1:0] sat_inc(input logic [N_BIT-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // A zero length still opens the gate for one cycle.
    function automatic logic [W_BIT-1:0] win_len_eff(input logic [W_BIT-1:0] len);
        return (len == '0) ? TIMER_ONE : len;
    endfunction

    evt_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_event(i_event),
        .o_edge (evt_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            result_q  <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            result_q  <= result_nxt;
            res_ovf_q <= res_ovf_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        cnt_nxt     = cnt;
        ovf_nxt     = ovf;
        result_nxt  = result_q;
        res_ovf_nxt = res_ovf_q;
        // An edge arriving at the ceiling is lost and flags overflow.
        cnt_upd     = evt_edge ? sat_inc(cnt) : cnt;
        ovf_upd     = ovf | (evt_edge & (cnt == CNT_MAX));

        case (state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_nxt = ST_COUNT;
                    timer_nxt = win_len_eff(i_win_len);
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt   = cnt_upd;
                    ovf_nxt   = ovf_upd;
                    timer_nxt = timer - 1'b1;
                    // Last gate cycle: its own edge is folded into the frozen result.
                    if (timer == TIMER_ONE) begin
                        result_nxt  = cnt_upd;
                        res_ovf_nxt = ovf_upd;
                        state_nxt   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (i_abort || i_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy     = (state == ST_COUNT) || (state == ST_HOLD);
    assign o_gate     = (state == ST_COUNT);
    assign o_valid    = (state == ST_HOLD);
    assign o_result   = result_q;
    assign o_overflow = res_ovf_q;

endmodule

// File: tb/tb_gate_window_ctrl.sv
// Directed bench for gate_window_ctrl (default build, no event synchronizer).
// A 12-bit and a 4-bit counter instance share all inputs.
module tb_gate_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_win_len = 16'd0;
    logic        i_abort = 1'b0;
    logic        i_event = 1'b0;
    logic        i_ready = 1'b0;

    logic        busy, gate, ovf, valid;
    logic [11:0] result;
    logic        busy4, gate4, ovf4, valid4;
    logic [3:0]  result4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_window_ctrl #(.N_BIT(12), .W_BIT(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_win_len(i_win_len), .i_abort(i_abort),
        .i_event(i_event), .o_busy(busy), .o_gate(gate), .o_result(result),
        .o_overflow(ovf), .o_valid(valid), .i_ready(i_ready)
    );

    gate_window_ctrl #(.N_BIT(4), .W_BIT(16), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_win_len(i_win_len), .i_abort(i_abort),
        .i_event(i_event), .o_busy(busy4), .o_gate(gate4), .o_result(result4),
        .o_overflow(ovf4), .o_valid(valid4), .i_ready(i_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input logic [15:0] len);
        i_start   = 1'b1;
        i_win_len = len;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic ack();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate got=%0b exp=0", gate); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (result !== 12'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        checks++; if ({busy4, gate4, valid4, ovf4, result4} !== 8'd0) begin
            failures++; $display("FAIL reset_dut4 got=%0h exp=0", {busy4, gate4, valid4, ovf4, result4});
        end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%0b exp=0", busy); end
    endtask

    task automatic test_count_pulses();
        i_event = 1'b0;
        start_win(16'd10);
        for (int c = 1; c <= 10; c++) begin
            i_event = (c == 2 || c == 4 || c == 6 || c == 8);
            checks++; if (gate !== 1'b1) begin failures++; $display("FAIL pulses_gate c=%0d got=%0b exp=1", c, gate); end
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL pulses_early_valid c=%0d got=%0b exp=0", c, valid); end
            tick();
        end
        i_event = 1'b0;
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL pulses_valid got=%0b exp=1", valid); end
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL pulses_gate_closed got=%0b exp=0", gate); end
        checks++; if (result !== 12'd4) begin failures++; $display("FAIL pulses_result got=%0d exp=4", result); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL pulses_ovf got=%0b exp=0", ovf); end
        ack();
        checks++; if ({busy, valid} !== 2'b00) begin failures++; $display("FAIL pulses_ack busy/valid got=%0b%0b exp=00", busy, valid); end
    endtask

    task automatic test_level_high();
        i_event = 1'b1;
        tick(); tick(); tick();
        start_win(16'd10);
        for (int c = 1; c <= 10; c++) tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL level_valid got=%0b exp=1", valid); end
        checks++; if (result !== 12'd0) begin failures++; $display("FAIL level_preheld_result got=%0d exp=0", result); end
        ack();
        i_event = 1'b0;
        tick();
        start_win(16'd10);
        for (int c = 1; c <= 10; c++) begin
            i_event = (c >= 3);
            tick();
        end
        i_event = 1'b0;
        checks++; if (result !== 12'd1) begin failures++; $display("FAIL level_rise_c3_result got=%0d exp=1", result); end
        ack();
    endtask

    task automatic test_zero_len();
        start_win(16'd0);
        i_event = 1'b1;
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL zlen_gate got=%0b exp=1", gate); end
        tick();
        i_event = 1'b0;
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL zlen_gate_one_cycle got=%0b exp=0", gate); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL zlen_valid got=%0b exp=1", valid); end
        checks++; if (result !== 12'd1) begin failures++; $display("FAIL zlen_result got=%0d exp=1", result); end
        ack();
    endtask

    task automatic test_saturate();
        i_event = 1'b0;
        start_win(16'd50);
        for (int c = 1; c <= 50; c++) begin
            i_event = (c % 2 == 1);
            tick();
        end
        i_event = 1'b0;
        checks++; if (valid4 !== 1'b1) begin failures++; $display("FAIL sat4_valid got=%0b exp=1", valid4); end
        checks++; if (result4 !== 4'd15) begin failures++; $display("FAIL sat4_result got=%0d exp=15", result4); end
        checks++; if (ovf4 !== 1'b1) begin failures++; $display("FAIL sat4_ovf got=%0b exp=1", ovf4); end
        checks++; if (result !== 12'd25) begin failures++; $display("FAIL sat12_result got=%0d exp=25", result); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat12_ovf got=%0b exp=0", ovf); end
        ack();
    endtask

    task automatic test_hold_backpressure();
        start_win(16'd3);
        for (int c = 1; c <= 3; c++) begin
            i_event = (c == 2);
            tick();
        end
        i_event = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_start   = (k == 2);
            i_win_len = 16'd5;
            tick();
            i_start = 1'b0;
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL hold_valid k=%0d got=%0b exp=1", k, valid); end
            checks++; if (result !== 12'd1) begin failures++; $display("FAIL hold_result k=%0d got=%0d exp=1", k, result); end
            checks++; if ({busy, gate} !== 2'b10) begin failures++; $display("FAIL hold_busy_gate k=%0d got=%0b%0b exp=10", k, busy, gate); end
        end
        ack();
        checks++; if ({busy, valid} !== 2'b00) begin failures++; $display("FAIL hold_ack busy/valid got=%0b%0b exp=00", busy, valid); end
        tick();
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL hold_no_restart gate got=%0b exp=0", gate); end
    endtask

    task automatic test_abort();
        start_win(16'd10);
        tick(); tick(); tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++; if ({busy, gate} !== 2'b00) begin failures++; $display("FAIL abort_count busy/gate got=%0b%0b exp=00", busy, gate); end
        for (int k = 0; k < 12; k++) begin
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL abort_no_valid k=%0d got=%0b exp=0", k, valid); end
            tick();
        end
        i_start = 1'b1; i_abort = 1'b1; i_win_len = 16'd4;
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_blocks_start busy got=%0b exp=0", busy); end
        start_win(16'd1);
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL abort_hold_gate got=%0b exp=1", gate); end
        tick();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL abort_hold_valid got=%0b exp=1", valid); end
        i_abort = 1'b1; i_ready = 1'b1;
        tick();
        i_abort = 1'b0; i_ready = 1'b0;
        checks++; if ({busy, valid} !== 2'b00) begin failures++; $display("FAIL abort_hold busy/valid got=%0b%0b exp=00", busy, valid); end
    endtask

    task automatic test_async_reset();
        start_win(16'd2);
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        tick();
        ack();
        checks++; if (result !== 12'd1) begin failures++; $display("FAIL result_kept_after_ack got=%0d exp=1", result); end
        start_win(16'd10);
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, gate, valid, ovf} !== 4'b0000) begin
            failures++; $display("FAIL async_rst flags got=%0b%0b%0b%0b exp=0000", busy, gate, valid, ovf);
        end
        checks++; if (result !== 12'd0) begin failures++; $display("FAIL async_rst_result got=%0d exp=0", result); end
        #2 rst = 1'b0;
        tick();
        checks++; if ({busy, gate} !== 2'b00) begin failures++; $display("FAIL post_rst_idle busy/gate got=%0b%0b exp=00", busy, gate); end
        start_win(16'd1);
        i_event = 1'b1;
        tick();
        i_event = 1'b0;
        checks++; if ({valid, result} !== {1'b1, 12'd1}) begin
            failures++; $display("FAIL post_rst_measure valid=%0b result=%0d exp valid=1 result=1", valid, result);
        end
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_count_pulses();
        test_level_high();
        test_zero_len();
        test_saturate();
        test_hold_backpressure();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
